// File: rtl/pc_sequencer_if.sv
// Handshake and bus bundle between the PC sequencer and its environment.
// PC_WRAP_TRAP_EN adds the sticky pc_wrap status line.
interface pc_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              fetch_ack;
    logic              halt_req;
    logic              jump;
    logic              branch_taken;
    logic [ADDR_W-1:0] target;
    logic              stall;
    logic [ADDR_W-1:0] pc;
    logic              fetch_req;
    logic              ir_load;
    logic              exec_en;
    logic              wb_en;
    logic              halted;
    logic [2:0]        state;
`ifdef PC_WRAP_TRAP_EN
    logic              pc_wrap;
`endif

    modport master (
`ifdef PC_WRAP_TRAP_EN
        output pc_wrap,
`endif
        input  start, fetch_ack, halt_req, jump,
        input  branch_taken, target, stall,
        output pc, fetch_req, ir_load, exec_en,
        output wb_en, halted, state
    );

    modport slave (
`ifdef PC_WRAP_TRAP_EN
        input  pc_wrap,
`endif
        output start, fetch_ack, halt_req, jump,
        output branch_taken, target, stall,
        input  pc, fetch_req, ir_load, exec_en,
        input  wb_en, halted, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning the PC.
// Define PC_WRAP_TRAP_EN to halt (sticky pc_wrap) on sequential PC overflow.
module pc_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pc_sequencer_if.master    bus
);
    localparam logic [ADDR_W-1:0] LP_RST_PC = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
`ifdef PC_WRAP_TRAP_EN
    logic              r_wrap;
    logic              w_wrap_nxt;
`endif

    // State, PC and trap flag registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= LP_RST_PC;
`ifdef PC_WRAP_TRAP_EN
            r_wrap  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
`ifdef PC_WRAP_TRAP_EN
            r_wrap  <= w_wrap_nxt;
`endif
        end
    end

    // Next-state and PC update; PC moves only when EXECUTE completes
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
`ifdef PC_WRAP_TRAP_EN
        w_wrap_nxt  = r_wrap;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (bus.fetch_ack) w_state_nxt = S_DEC;
            end
            S_DEC: begin
                w_state_nxt = bus.halt_req ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (!bus.stall) begin
                    if (bus.jump | bus.branch_taken) begin
                        w_pc_nxt    = bus.target;
                        w_state_nxt = S_WB;
                    end
`ifdef PC_WRAP_TRAP_EN
                    else if (&r_pc) begin
                        w_wrap_nxt  = 1'b1;
                        w_state_nxt = S_HALT;
                    end
`endif
                    else begin
                        w_pc_nxt    = r_pc + ADDR_W'(1);
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.pc        = r_pc;
    assign bus.state     = r_state;
    assign bus.fetch_req = (r_state == S_FETCH);
    assign bus.ir_load   = (r_state == S_FETCH) & bus.fetch_ack;
    assign bus.exec_en   = (r_state == S_EXEC);
    assign bus.wb_en     = (r_state == S_WB);
    assign bus.halted    = (r_state == S_HALT);
`ifdef PC_WRAP_TRAP_EN
    assign bus.pc_wrap   = r_wrap;
`endif

endmodule
